// File: rtl/cacheline_adaptor_pkg.sv
// ----------------------------------------------------------------------------
// cacheline_adaptor_pkg
//   Shared constants and the state type for the cache-line to burst adaptor.
//   LINE_W / BURST_W fix the beat count; BEATS is derived and not meant to be
//   overridden. OFFSET_W is the number of byte-offset bits dropped from the
//   line address before it goes to memory.
// ----------------------------------------------------------------------------
package cacheline_adaptor_pkg;

    localparam int LINE_W   = 256;
    localparam int BURST_W  = 64;
    localparam int ADDR_W   = 32;
    localparam int BEATS    = LINE_W / BURST_W;
    localparam int OFFSET_W = 5;
    localparam int CNT_W    = $clog2(BEATS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } adaptor_state_t;

endpackage

// File: rtl/cacheline_adaptor.sv
// ----------------------------------------------------------------------------
// cacheline_adaptor
//   Bridges the L1 cache's 256-bit line port and a 64-bit burst memory. Each
//   line read or write becomes a 4-beat burst; the cache gets a one-cycle
//   resp_o once the whole line has moved. Only one request is in flight.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for read_i / write_i (read wins); latches the request
//   READ  | collecting beats from burst_i on each resp_i
//   WRITE | presenting buffer beats on burst_o, advancing on resp_i
//   RESP  | one-cycle resp_o to the cache, count cleared
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   line_i / line_o       write line from cache / last read line to cache
//   address_i             line address from cache (offset bits ignored)
//   read_i, write_i       cache line requests
//   resp_o                line transfer complete (single-cycle pulse)
//   burst_i / burst_o     read beat from memory / write beat to memory
//   address_o             line-aligned burst address
//   read_o, write_o       burst requests to memory
//   resp_i                memory beat valid / accepted
// ----------------------------------------------------------------------------
module cacheline_adaptor
    import cacheline_adaptor_pkg::*;
(
    input  logic                clk,
    input  logic                rst,

    input  logic [LINE_W-1:0]   line_i,
    output logic [LINE_W-1:0]   line_o,
    input  logic [ADDR_W-1:0]   address_i,
    input  logic                read_i,
    input  logic                write_i,
    output logic                resp_o,

    input  logic [BURST_W-1:0]  burst_i,
    output logic [BURST_W-1:0]  burst_o,
    output logic [ADDR_W-1:0]   address_o,
    output logic                read_o,
    output logic                write_o,
    input  logic                resp_i
);

    adaptor_state_t     r_state;
    logic [CNT_W-1:0]   r_count;
    logic [BURST_W-1:0] r_buf [BEATS];
    logic [LINE_W-1:0]  r_line;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_read;
    logic               r_write;
    logic               r_resp;

    logic               w_last_beat;

    assign w_last_beat = resp_i && (r_count == CNT_W'(BEATS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_count <= '0;
            r_line  <= '0;
            r_addr  <= '0;
            r_read  <= 1'b0;
            r_write <= 1'b0;
            r_resp  <= 1'b0;
            for (int k = 0; k < BEATS; k++) begin
                r_buf[k] <= '0;
            end
        end else begin
            r_resp <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_count <= '0;
                    if (read_i) begin
                        r_addr  <= address_i;
                        r_read  <= 1'b1;
                        r_state <= READ;
                    end else if (write_i) begin
                        r_addr  <= address_i;
                        r_write <= 1'b1;
                        r_state <= WRITE;
                        for (int k = 0; k < BEATS; k++) begin
                            r_buf[k] <= line_i[k*BURST_W +: BURST_W];
                        end
                    end
                end

                READ: begin
                    if (resp_i) begin
                        r_buf[r_count] <= burst_i;
                        r_count        <= r_count + 1'b1;
                        // read_o only needs to be seen until memory starts answering
                        r_read         <= 1'b0;
                        if (w_last_beat) begin
                            // line_o is a separate copy so that a later write,
                            // which reuses r_buf, does not disturb the read line
                            for (int k = 0; k < BEATS; k++) begin
                                r_line[k*BURST_W +: BURST_W] <=
                                    (k == BEATS - 1) ? burst_i : r_buf[k];
                            end
                            r_resp  <= 1'b1;
                            r_state <= RESP;
                        end
                    end
                end

                WRITE: begin
                    if (resp_i) begin
                        r_count <= r_count + 1'b1;
                        if (w_last_beat) begin
                            r_write <= 1'b0;
                            r_resp  <= 1'b1;
                            r_state <= RESP;
                        end
                    end
                end

                RESP: begin
                    r_count <= '0;
                    r_state <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign line_o    = r_line;
    assign resp_o    = r_resp;
    assign read_o    = r_read;
    assign write_o   = r_write;
    assign burst_o   = r_buf[r_count];
    assign address_o = {r_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};

endmodule

// File: tb/tb_cacheline_adaptor.sv
module tb_cacheline_adaptor;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [255:0] line_i = '0;
    logic [255:0] line_o;
    logic [31:0]  address_i = '0;
    logic         read_i = 1'b0;
    logic         write_i = 1'b0;
    logic         resp_o;
    logic [63:0]  burst_i = '0;
    logic [63:0]  burst_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic         resp_i = 1'b0;

    always #5 clk = ~clk;

    cacheline_adaptor dut (
        .clk       (clk),
        .rst       (rst),
        .line_i    (line_i),
        .line_o    (line_o),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .resp_o    (resp_o),
        .burst_i   (burst_i),
        .burst_o   (burst_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .resp_i    (resp_i)
    );

    typedef struct {
        bit           is_read;
        logic [31:0]  addr;
        logic [255:0] line;
    } exp_t;

    exp_t          sb_q[$];
    logic [255:0]  ref_mem   [logic [31:0]];   // reference: what the cache expects memory to hold
    logic [255:0]  mem_store [logic [31:0]];   // environment: what the memory model actually holds
    int            n_checks = 0;
    int            n_pass   = 0;
    int            cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [255:0] act, logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // contents of a line nobody has written yet
    function automatic logic [255:0] dflt(logic [31:0] a);
        logic [255:0] r;
        for (int k = 0; k < 4; k++)
            r[k*64 +: 64] = {a ^ 32'(32'h9E37_79B9 * (k + 1)), a + 32'(32'h0101_0101 * k)};
        return r;
    endfunction

    function automatic logic [255:0] rnd_line();
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [255:0] ref_read(logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return dflt(a);
    endfunction

    // ------------------------------------------------------------------
    // Burst memory model: answers one burst at a time with optional gaps
    // ------------------------------------------------------------------
    int           gap_q[$];
    bit           gap_rand = 1'b0;
    bit           mem_busy = 1'b0;
    bit           mem_isread;
    bit           mem_shape_ok;
    bit           mem_last_shape_ok = 1'b0;
    int           mem_beat = 0;
    int           mem_gap;
    int           mem_last_cyc = 0;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_last_addr = '0;
    logic [255:0] mem_rline;
    logic [255:0] mem_wline;
    logic [255:0] mem_last_wline = '0;

    always @(negedge clk) begin
        if (rst) begin
            mem_busy = 1'b0;
            mem_beat = 0;
            resp_i   = 1'b0;
        end else begin
            resp_i  = 1'b0;
            burst_i = {$urandom, $urandom};
            if (!mem_busy && (read_o || write_o)) begin
                mem_busy     = 1'b1;
                mem_isread   = read_o;
                mem_addr     = address_o;
                mem_beat     = 0;
                mem_shape_ok = 1'b1;
                mem_rline    = mem_store.exists(address_o) ? mem_store[address_o] : dflt(address_o);
                if (gap_q.size() > 0) mem_gap = gap_q.pop_front();
                else mem_gap = gap_rand ? int'($urandom_range(0, 2)) : 0;
            end
            if (mem_busy) begin
                if (mem_isread) begin
                    if (read_o !== (mem_beat == 0) || write_o !== 1'b0) mem_shape_ok = 1'b0;
                end else begin
                    if (write_o !== 1'b1 || read_o !== 1'b0) mem_shape_ok = 1'b0;
                end
                if (address_o !== mem_addr) mem_shape_ok = 1'b0;
                if (mem_gap > 0) begin
                    mem_gap--;
                end else begin
                    resp_i = 1'b1;
                    if (mem_isread) burst_i = mem_rline[mem_beat*64 +: 64];
                    else mem_wline[mem_beat*64 +: 64] = burst_o;
                    mem_beat++;
                    if (mem_beat == 4) begin
                        mem_busy          = 1'b0;
                        mem_last_cyc      = cyc;
                        mem_last_addr     = mem_addr;
                        mem_last_shape_ok = mem_shape_ok;
                        if (!mem_isread) begin
                            mem_last_wline      = mem_wline;
                            mem_store[mem_addr] = mem_wline;
                        end
                    end else begin
                        if (gap_q.size() > 0) mem_gap = gap_q.pop_front();
                        else mem_gap = gap_rand ? int'($urandom_range(0, 2)) : 0;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Monitor: pops the scoreboard on every resp_o
    // ------------------------------------------------------------------
    logic [255:0] last_rd_line = '0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            last_rd_line = '0;
        end else if (resp_o) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                $display("FAIL spurious_resp: resp_o=1 with no request outstanding, expected 0");
            end else begin
                e = sb_q.pop_front();
                check("resp_latency", cyc, mem_last_cyc + 1);
                check("req_low_in_resp", {read_o, write_o}, 2'b00);
                check("burst_shape", mem_last_shape_ok, 1'b1);
                check("address_o", mem_last_addr, e.addr);
                if (e.is_read) begin
                    check("read_line", line_o, e.line);
                    last_rd_line = e.line;
                end else begin
                    check("write_line", mem_last_wline, e.line);
                    check("line_o_hold", line_o, last_rd_line);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus (cache side)
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_req(bit rd, bit wr, logic [31:0] addr, logic [255:0] line, bit scramble);
        logic [31:0] al;
        exp_t        e;
        int          t;
        al = {addr[31:5], 5'b0};
        if (rd) begin
            e.is_read = 1'b1; e.addr = al; e.line = ref_read(al);
            sb_q.push_back(e);
        end else if (wr) begin
            e.is_read = 1'b0; e.addr = al; e.line = line;
            sb_q.push_back(e);
            ref_mem[al] = line;
        end
        read_i = rd; write_i = wr; address_i = addr; line_i = line;
        for (t = 0; t < 200; t++) begin
            tick();
            if (resp_o) break;
            if (scramble) begin
                address_i = $urandom;
                line_i    = rnd_line();
            end
        end
        if (t == 200) begin
            n_checks++;
            $display("FAIL resp_timeout: resp_o not seen within 200 cycles, expected a pulse");
            sb_q.delete();
        end
        read_i = 1'b0; write_i = 1'b0;
        tick();
    endtask

    initial begin
        logic [255:0] l;
        logic [31:0]  pool [4];
        int           t;

        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("reset_resp_o", resp_o, 1'b0);
        check("reset_read_o", read_o, 1'b0);
        check("reset_write_o", write_o, 1'b0);
        check("reset_line_o", line_o, '0);
        check("reset_burst_o", burst_o, '0);
        check("reset_address_o", address_o, '0);

        // directed read, back-to-back beats
        l = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
             64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        mem_store[32'h0000_1220] = l;
        ref_mem[32'h0000_1220]   = l;
        do_req(1'b1, 1'b0, 32'h0000_1234, '0, 1'b0);
        check("dir_read_addr", mem_last_addr, 32'h0000_1220);

        // directed write, beat order
        l = {64'hDEAD_BEEF_0000_0003, 64'hDEAD_BEEF_0000_0002,
             64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0000};
        do_req(1'b0, 1'b1, 32'h0000_8000, l, 1'b0);

        // read back with resp_i pattern 1,0,0,1,0,1,1
        gap_q = '{0, 2, 1, 0};
        do_req(1'b1, 1'b0, 32'h0000_8010, '0, 1'b0);

        // read and write together: read only
        do_req(1'b1, 1'b1, 32'h0000_4000, rnd_line(), 1'b0);

        // reset after two read beats
        begin
            exp_t e;
            e.is_read = 1'b1; e.addr = 32'h0000_2000; e.line = ref_read(32'h0000_2000);
            sb_q.push_back(e);
            read_i = 1'b1; address_i = 32'h0000_2000;
            for (t = 0; t < 100; t++) begin
                tick();
                if (mem_busy && mem_beat == 2) break;
            end
            if (t == 100) begin
                n_checks++;
                $display("FAIL rst_setup_timeout: two beats not reached, expected within 100 cycles");
            end
            rst = 1'b1; read_i = 1'b0;
            void'(sb_q.pop_back());
            tick();
            check("midrst_read_o", read_o, 1'b0);
            check("midrst_resp_o", resp_o, 1'b0);
            check("midrst_address_o", address_o, '0);
            rst = 1'b0;
            tick();
        end
        do_req(1'b1, 1'b0, 32'h0000_1220, '0, 1'b0);

        // back-to-back writes then read both back
        do_req(1'b0, 1'b1, 32'h0000_a000, rnd_line(), 1'b0);
        do_req(1'b0, 1'b1, 32'h0000_a020, rnd_line(), 1'b0);
        do_req(1'b1, 1'b0, 32'h0000_a000, '0, 1'b0);
        do_req(1'b1, 1'b0, 32'h0000_a03f, '0, 1'b0);

        // randomized traffic with gaps and request changes while busy
        gap_rand = 1'b1;
        for (int k = 0; k < 4; k++) pool[k] = $urandom & 32'hFFFF_FFE0;
        for (int n = 0; n < 30; n++) begin
            logic [31:0] a;
            a = pool[$urandom_range(0, 3)] | 32'($urandom_range(0, 31));
            case ($urandom_range(0, 2))
                0: do_req(1'b1, 1'b0, a, '0, 1'b1);
                1: do_req(1'b0, 1'b1, a, rnd_line(), 1'b1);
                default: do_req(1'b1, 1'b1, a, rnd_line(), 1'b1);
            endcase
        end

        repeat (5) tick();
        check("scoreboard_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cacheline_adaptor.md
Name: cacheline_adaptor

Overview:
- Sits between the L1 cache's 256-bit physical-memory port and the 64-bit burst memory.
- Converts each cache line read or write into a 4-beat burst transaction.
- Returns a single-cycle response to the cache when the whole line has transferred.
- Provides the cache with an atomic line interface; it does not reorder, combine or buffer more than one request.

Parameters:
- LINE_W, 256, cache line width in bits.
- BURST_W, 64, memory beat width in bits.
- ADDR_W, 32, address width.
- BEATS, LINE_W/BURST_W (=4), derived; beats per line. Not overridable.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- line_i  in  LINE_W  write line from cache (pmem_wdata).
- line_o  out  LINE_W  read line to cache (pmem_rdata).
- address_i  in  ADDR_W  line address from cache (pmem_address).
- read_i  in  1  cache line read request (pmem_read).
- write_i  in  1  cache line write request (pmem_write).
- resp_o  out  1  line transfer complete (pmem_resp).
- burst_i  in  BURST_W  read beat from memory.
- burst_o  out  BURST_W  write beat to memory.
- address_o  out  ADDR_W  burst address to memory.
- read_o  out  1  burst read request.
- write_o  out  1  burst write request.
- resp_i  in  1  memory beat valid/accepted.

Behaviour:
- Reset: state=IDLE, beat count=0, line buffer=0, address register=0. Outputs: resp_o=0, read_o=0, write_o=0, line_o=0, burst_o=0, address_o=0.
- Reset mid-burst: the burst is abandoned and the block returns to IDLE the next cycle. The memory is required to be reset in the same cycle.
- Address alignment: address_o = {addr_reg[31:5], 5'b0}. Offset bits from the cache are ignored.
- Beat order: beat k maps to line bits [64k+63 : 64k], k = 0..3. Beat 0 is transferred first.

State machine IDLE / READ / WRITE / RESP:
- IDLE:
  - If read_i=1: latch address_i; go to READ. read_o=1 from the next cycle.
  - Else if write_i=1: latch address_i and line_i; go to WRITE.
  - read_i has priority if read_i and write_i are both 1; write_i is ignored.
  - resp_i in IDLE is ignored.
- READ:
  - read_o=1 until the cycle the first resp_i is seen, then 0.
  - On each cycle with resp_i=1: buffer[count] <= burst_i; count++.
  - The cycle with resp_i=1 and count=3 captures beat 3; go to RESP.
  - Gaps (resp_i=0 between beats) are legal and hold state.
- WRITE:
  - write_o=1 for the whole state.
  - burst_o = buffer[count], updated combinationally from count.
  - On resp_i=1: count++. The cycle with resp_i=1 and count=3 goes to RESP; write_o drops there.
- RESP:
  - resp_o=1 for exactly one cycle. line_o = buffer (valid for reads, don't-care for writes).
  - count <= 0; go to IDLE.
  - The cache drops its request at the edge where it sees resp_o, so IDLE on the following cycle does not retrigger.
- line_o holds the last read line until the next read completes.
- Latency:
  - Read: request cycle + 1 to assert read_o, then 4 beats, then 1 RESP cycle. Minimum 6 cycles from read_i to resp_o.
  - Write: same structure. Minimum 6 cycles, with write_o asserted starting in the cycle after write_i.
- Back-to-back requests: a new request is accepted at the earliest in the IDLE cycle after RESP. There is no pipelining.
- Protocol errors:
  - Request changes while busy: the change is ignored; latched values are used.
  - Extra resp_i after beat 3: ignored (RESP/IDLE).

Decomposition:
- Shared package (beside rv32i_types): constants LINE_W, BURST_W, BEATS, OFFSET_W=5, and typedef enum adaptor_state_t {IDLE, READ, WRITE, RESP}.
- No sub-module; the line buffer plus 2-bit count is small enough to stay inline.

Test Plan:
- Read at address_i=0x0000_1234; memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 back-to-back.
  - Required: address_o=0x0000_1220 and read_o high until beat 0.
  - Required: resp_o pulses once, 1 cycle after beat 3.
  - Required: line_o = {0x44..,0x33..,0x22..,0x11..}.
- Write line 0xDEAD..BEEF pattern to 0x0000_8000, memory resp_i every cycle.
  - Required: burst_o shows line[63:0], [127:64], [191:128], [255:192] in order, with write_o high for all 4 beats.
  - Required: resp_o after the 4th beat.
- Read with gaps: resp_i pattern 1,0,0,1,0,1,1.
  - Required: all 4 beats captured in order, with no duplicated or skipped beats.
  - Required: resp_o exactly 1 cycle after the last resp_i.
- read_i and write_i asserted together in IDLE → read burst only, write_o stays 0 throughout.
- rst asserted after 2 read beats.
  - Required: next cycle state IDLE, read_o=0, resp_o=0.
  - Required: a subsequent read completes correctly with count starting at 0.
- Two back-to-back writes, the cache reasserting write_i the cycle after resp_o → second burst starts, no spurious resp_o between them.
